// File: rtl/pong_engine.sv
// Pong game engine: game FSM, paddle and ball motion, scoring, and
// combinational paddle/ball rendering from the registered positions.
module pong_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_LEN      = 108,
    parameter int PAD_W        = 6,
    parameter int PAD_V        = 4,
    parameter int PAD_L_X      = 40,
    parameter int PAD_R_X      = 600,
    parameter int BALL_V       = 3,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [1:0]         btn_l,
    input  logic [1:0]         btn_r,
    input  logic               start,
    output logic               graph_on,
    output logic [2:0]         graph_rgb,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         winner,
    output logic               hit_l,
    output logic               hit_r,
    output logic               miss,
    output logic [1:0]         state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SERVE = 2'b01,
        S_PLAY  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] BALL_X0   = 10'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BALL_Y0   = 10'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [9:0] PAD_Y0    = 10'(V_RES / 2 - PAD_LEN / 2);
    localparam logic [9:0] PAD_MAX   = 10'(V_RES - PAD_LEN);
    localparam logic [9:0] BALL_YMAX = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] BALL_XL   = 10'(PAD_L_X + PAD_W);
    localparam logic [9:0] BALL_XR   = 10'(PAD_R_X - BALL_SIZE);
    localparam logic [9:0] STEP_B    = 10'(BALL_V);
    localparam logic [9:0] STEP_P    = 10'(PAD_V);

    // 11-bit operands so edge sums near the screen limits never wrap
    localparam logic [10:0] W_BV     = 11'(BALL_V);
    localparam logic [10:0] W_BS     = 11'(BALL_SIZE);
    localparam logic [10:0] W_LE     = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] W_PLX    = 11'(PAD_L_X);
    localparam logic [10:0] W_PRX    = 11'(PAD_R_X);
    localparam logic [10:0] W_PW     = 11'(PAD_W);
    localparam logic [10:0] W_PL     = 11'(PAD_LEN);
    localparam logic [10:0] W_H      = 11'(H_RES);
    localparam logic [10:0] W_V      = 11'(V_RES);
    localparam logic [10:0] W_TICK_Y = 11'(V_RES + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    state_t             state_q, state_d;
    logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]         pad_l_q, pad_l_d, pad_r_q, pad_r_d;
    logic               dir_x_q, dir_x_d;   // 1 = moving right
    logic               dir_y_q, dir_y_d;   // 1 = moving down
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [1:0]         winner_q, winner_d;
    logic               hit_l_q, hit_l_d, hit_r_q, hit_r_d, miss_q, miss_d;

    logic               tick;
    logic [10:0]        bx, by, pl, pr, px, py;
    logic               ovl_l, ovl_r, hit_l_c, hit_r_c, miss_lo, miss_hi;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;
    logic               pad_on, ball_on;

    // Paddle step with clamping; both or neither button means no move
    function automatic logic [9:0] pad_step(input logic [9:0] top, input logic [1:0] btn);
        logic [9:0] nxt;
        nxt = top;
        if (btn == 2'b01)
            nxt = (top < STEP_P) ? 10'd0 : top - STEP_P;
        else if (btn == 2'b10)
            nxt = ({1'b0, top} + {1'b0, STEP_P} > {1'b0, PAD_MAX}) ? PAD_MAX : top + STEP_P;
        return nxt;
    endfunction

    assign tick = (pix_x == 10'd0) && ({1'b0, pix_y} == W_TICK_Y);
    assign bx   = {1'b0, ball_x_q};
    assign by   = {1'b0, ball_y_q};
    assign pl   = {1'b0, pad_l_q};
    assign pr   = {1'b0, pad_r_q};
    assign px   = {1'b0, pix_x};
    assign py   = {1'b0, pix_y};

    assign ovl_l   = (by + W_BS > pl) && (by < pl + W_PL);
    assign ovl_r   = (by + W_BS > pr) && (by < pr + W_PL);
    assign hit_l_c = !dir_x_q && (bx >= W_LE) && (bx < W_LE + W_BV) && ovl_l;
    assign hit_r_c = dir_x_q && (bx + W_BS <= W_PRX) && (bx + W_BS + W_BV > W_PRX) && ovl_r;
    assign miss_lo = !dir_x_q && (bx < W_BV);                // out on the left: right scores
    assign miss_hi = dir_x_q && (bx + W_BS + W_BV > W_H);    // out on the right: left scores

    assign score_l_inc = score_l_q + SCORE_ONE;
    assign score_r_inc = score_r_q + SCORE_ONE;

    // Game FSM next state, motion, scoring and event pulses
    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        pad_l_d   = pad_l_q;
        pad_r_d   = pad_r_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        hit_l_d   = 1'b0;
        hit_r_d   = 1'b0;
        miss_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                pad_l_d  = PAD_Y0;
                pad_r_d  = PAD_Y0;
                dir_x_d  = 1'b1;
                dir_y_d  = 1'b1;
                if (start) begin
                    state_d   = S_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 2'b00;
                    cnt_d     = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                if (tick) begin
                    pad_l_d = pad_step(pad_l_q, btn_l);
                    pad_r_d = pad_step(pad_r_q, btn_r);
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE)
                        state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    pad_l_d = pad_step(pad_l_q, btn_l);
                    pad_r_d = pad_step(pad_r_q, btn_r);
                    if (!dir_y_q && ball_y_q < STEP_B) begin
                        ball_y_d = 10'd0;
                        dir_y_d  = 1'b1;
                    end else if (dir_y_q && by + W_BS + W_BV > W_V) begin
                        ball_y_d = BALL_YMAX;
                        dir_y_d  = 1'b0;
                    end else if (dir_y_q) begin
                        ball_y_d = ball_y_q + STEP_B;
                    end else begin
                        ball_y_d = ball_y_q - STEP_B;
                    end
                    if (hit_l_c) begin
                        ball_x_d = BALL_XL;
                        dir_x_d  = 1'b1;
                        hit_l_d  = 1'b1;
                    end else if (hit_r_c) begin
                        ball_x_d = BALL_XR;
                        dir_x_d  = 1'b0;
                        hit_r_d  = 1'b1;
                    end else if (miss_lo || miss_hi) begin
                        // Re-serve toward the player who missed, vertical direction flipped
                        miss_d   = 1'b1;
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                        cnt_d    = SERVE_LOAD;
                        dir_y_d  = !dir_y_q;
                        state_d  = S_SERVE;
                        if (miss_hi) begin
                            score_l_d = score_l_inc;
                            dir_x_d   = 1'b1;
                            if (score_l_inc == WIN_VAL) begin
                                state_d  = S_OVER;
                                winner_d = 2'b01;
                            end
                        end else begin
                            score_r_d = score_r_inc;
                            dir_x_d   = 1'b0;
                            if (score_r_inc == WIN_VAL) begin
                                state_d  = S_OVER;
                                winner_d = 2'b10;
                            end
                        end
                    end else if (dir_x_q) begin
                        ball_x_d = ball_x_q + STEP_B;
                    end else begin
                        ball_x_d = ball_x_q - STEP_B;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d  = S_IDLE;
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    pad_l_d  = PAD_Y0;
                    pad_r_d  = PAD_Y0;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
                end
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ball_x_q  <= BALL_X0;
            ball_y_q  <= BALL_Y0;
            pad_l_q   <= PAD_Y0;
            pad_r_q   <= PAD_Y0;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            hit_l_q   <= 1'b0;
            hit_r_q   <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            pad_l_q   <= pad_l_d;
            pad_r_q   <= pad_r_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            hit_l_q   <= hit_l_d;
            hit_r_q   <= hit_r_d;
            miss_q    <= miss_d;
        end
    end

    // Pixel rendering: paddles always drawn, ball only while in play; paddle wins overlaps
    always_comb begin
        pad_on = ((px >= W_PLX) && (px < W_PLX + W_PW) && (py >= pl) && (py < pl + W_PL)) ||
                 ((px >= W_PRX) && (px < W_PRX + W_PW) && (py >= pr) && (py < pr + W_PL));
        ball_on = ((state_q == S_SERVE) || (state_q == S_PLAY)) &&
                  (px >= bx) && (px < bx + W_BS) && (py >= by) && (py < by + W_BS);
        graph_rgb = 3'b000;
        if (pad_on)
            graph_rgb = 3'b101;
        else if (ball_on)
            graph_rgb = 3'b100;
    end

    assign graph_on = pad_on | ball_on;
    assign score_l  = score_l_q;
    assign score_r  = score_r_q;
    assign winner   = winner_q;
    assign hit_l    = hit_l_q;
    assign hit_r    = hit_r_q;
    assign miss     = miss_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: directed game scenarios followed by a
// randomized phase, all compared against a behavioural game model.
module tb_pong_engine;
    localparam int H = 640, V = 480, BS = 8, PL = 108, PW = 6, PV = 4;
    localparam int PLX = 40, PRX = 600, BV = 3, WIN = 9, SF = 60;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [9:0] pix_x, pix_y;
    logic [1:0] btn_l, btn_r;
    logic       graph_on;
    logic [2:0] graph_rgb;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;
    logic       hit_l, hit_r, miss;
    logic [1:0] state;

    int n_cmp = 0, n_bad = 0;

    // Model: positions as plain integers, velocity as signed steps
    int m_mode, m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr, m_win, m_cnt;
    int m_hl, m_hr, m_miss;

    always #5 clk = ~clk;

    pong_engine dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .btn_l(btn_l), .btn_r(btn_r), .start(start),
        .graph_on(graph_on), .graph_rgb(graph_rgb),
        .score_l(score_l), .score_r(score_r), .winner(winner),
        .hit_l(hit_l), .hit_r(hit_r), .miss(miss), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic centre();
        m_bx = H / 2 - BS / 2;
        m_by = V / 2 - BS / 2;
        m_pl = V / 2 - PL / 2;
        m_pr = V / 2 - PL / 2;
        m_vx = BV;
        m_vy = BV;
    endtask

    function automatic int pad_move(input int top, input logic [1:0] b);
        if (b == 2'b01) return (top - PV < 0) ? 0 : top - PV;
        if (b == 2'b10) return (top + PV > V - PL) ? V - PL : top + PV;
        return top;
    endfunction

    function automatic bit overlap(input int y, input int top);
        return (y + BS > top) && (y < top + PL);
    endfunction

    // Advance the model across one clock edge
    task automatic model_edge(input bit tk, input logic [1:0] bl, input logic [1:0] br,
                              input bit st, input bit rs);
        int nx, ny, oby, ovy, opl, opr;
        m_hl = 0; m_hr = 0; m_miss = 0;
        if (rs) begin
            centre();
            m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                centre();
                if (st) begin
                    m_mode = M_SERVE; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = SF;
                end
            end
            M_SERVE: if (tk) begin
                m_pl = pad_move(m_pl, bl);
                m_pr = pad_move(m_pr, br);
                m_cnt--;
                if (m_cnt == 0) m_mode = M_PLAY;
            end
            M_PLAY: if (tk) begin
                oby = m_by; ovy = m_vy; opl = m_pl; opr = m_pr;
                m_pl = pad_move(m_pl, bl);
                m_pr = pad_move(m_pr, br);
                ny = m_by + m_vy;
                if (ny < 0) begin m_by = 0; m_vy = BV; end
                else if (ny + BS > V) begin m_by = V - BS; m_vy = -BV; end
                else m_by = ny;
                nx = m_bx + m_vx;
                if (m_vx < 0 && m_bx >= PLX + PW && nx < PLX + PW && overlap(oby, opl)) begin
                    m_bx = PLX + PW; m_vx = BV; m_hl = 1;
                end else if (m_vx > 0 && m_bx + BS <= PRX && nx + BS > PRX && overlap(oby, opr)) begin
                    m_bx = PRX - BS; m_vx = -BV; m_hr = 1;
                end else if (nx < 0 || nx + BS > H) begin
                    m_miss = 1;
                    if (nx < 0) m_sr++; else m_sl++;
                    m_bx = H / 2 - BS / 2;
                    m_by = V / 2 - BS / 2;
                    if (m_sl == WIN) begin m_mode = M_OVER; m_win = 1; end
                    else if (m_sr == WIN) begin m_mode = M_OVER; m_win = 2; end
                    else begin
                        m_mode = M_SERVE; m_cnt = SF;
                        m_vx = (nx < 0) ? -BV : BV;
                        m_vy = -ovy;
                    end
                end else m_bx = nx;
            end
            default: if (st) begin
                m_mode = M_IDLE;
                centre();
            end
        endcase
    endtask

    function automatic logic [2:0] exp_rgb(input int x, input int y);
        bit pad, ball;
        pad = (x >= PLX && x < PLX + PW && y >= m_pl && y < m_pl + PL) ||
              (x >= PRX && x < PRX + PW && y >= m_pr && y < m_pr + PL);
        ball = (m_mode == M_SERVE || m_mode == M_PLAY) &&
               x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS;
        if (pad) return 3'b101;
        if (ball) return 3'b100;
        return 3'b000;
    endfunction

    task automatic probe_at(input int x0, input int y0, input string tag);
        int x, y;
        logic [2:0] e;
        x = (x0 < 0) ? 0 : (x0 > H - 1) ? H - 1 : x0;
        y = (y0 < 0) ? 0 : (y0 > V) ? V : y0;
        pix_x = 10'(x); pix_y = 10'(y);
        #1;
        e = exp_rgb(x, y);
        chk({tag, "_rgb"}, graph_rgb, e);
        chk({tag, "_on"}, graph_on, e != 3'b000);
    endtask

    task automatic probe_rand();
        int sel;
        sel = int'($urandom_range(0, 2));
        if (sel == 0)
            probe_at(m_bx + int'($urandom_range(0, BS + 1)) - 1,
                     m_by + int'($urandom_range(0, BS + 1)) - 1, "pix_ball");
        else if (sel == 1)
            probe_at(PLX + int'($urandom_range(0, PW + 1)) - 1,
                     m_pl + int'($urandom_range(0, PL + 1)) - 1, "pix_padl");
        else
            probe_at(PRX + int'($urandom_range(0, PW + 1)) - 1,
                     m_pr + int'($urandom_range(0, PL + 1)) - 1, "pix_padr");
    endtask

    // One clock: drive inputs, advance model, compare registered outputs, probe a pixel
    task automatic step(input bit tk, input logic [1:0] bl, input logic [1:0] br,
                        input bit st, input bit rs);
        if (tk) begin pix_x = 10'd0; pix_y = 10'(V + 1); end
        btn_l = bl; btn_r = br; start = st; reset = rs;
        model_edge(tk, bl, br, st, rs);
        @(posedge clk);
        #1;
        chk("state", state, m_mode);
        chk("score_l", score_l, m_sl);
        chk("score_r", score_r, m_sr);
        chk("winner", winner, m_win);
        chk("hit_l", hit_l, m_hl);
        chk("hit_r", hit_r, m_hr);
        chk("miss", miss, m_miss);
        start = 1'b0; reset = 1'b0;
        probe_rand();
    endtask

    task automatic ticks(input int n, input logic [1:0] bl, input logic [1:0] br);
        for (int i = 0; i < n; i++) begin
            step(1'b1, bl, br, 1'b0, 1'b0);
            step(1'b0, bl, br, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit tk, st, rs;
        logic [1:0] bl, br;
        reset = 1'b1; start = 1'b0; btn_l = 2'b00; btn_r = 2'b00;
        pix_x = 10'd5; pix_y = 10'd5;
        centre();
        m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = 0;

        // Reset state, then reset overriding start
        step(0, 2'b00, 2'b00, 0, 1);
        step(0, 2'b00, 2'b00, 0, 1);
        chk("rst_state", state, 2'b00);
        chk("rst_score", score_l, 4'd0);
        step(0, 2'b00, 2'b00, 1, 1);
        chk("rst_start_idle", state, 2'b00);
        probe_at(316, 236, "idle_ball_hidden");
        chk("idle_ball_hidden_c", graph_rgb, 3'b000);

        // Serve delay then first moves
        step(0, 2'b00, 2'b00, 1, 0);
        chk("start_serve", state, 2'b01);
        ticks(59, 2'b00, 2'b00);
        chk("serve_hold", state, 2'b01);
        ticks(1, 2'b00, 2'b00);
        chk("serve_to_play", state, 2'b10);
        ticks(1, 2'b00, 2'b00);
        probe_at(319, 239, "ball_first");
        chk("ball_first_c", graph_rgb, 3'b100);
        probe_at(318, 239, "ball_first_left");
        chk("ball_first_left_c", graph_rgb, 3'b000);

        // Bottom bounce around PLAY ticks 78..80
        ticks(77, 2'b00, 2'b00);
        probe_at(550, 470, "t78");
        chk("t78_c", graph_rgb, 3'b100);
        ticks(1, 2'b00, 2'b00);
        probe_at(553, 472, "t79");
        chk("t79_c", graph_rgb, 3'b100);
        probe_at(553, 471, "t79_above");
        chk("t79_above_c", graph_rgb, 3'b000);
        ticks(1, 2'b00, 2'b00);
        probe_at(556, 469, "t80");
        chk("t80_c", graph_rgb, 3'b100);

        // Ball passes the right paddle and leaves the field at PLAY tick 106
        ticks(25, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 0, 0);
        chk("miss_pulse", miss, 1'b1);
        chk("miss_score_l", score_l, 4'd1);
        chk("miss_to_serve", state, 2'b01);
        step(0, 2'b00, 2'b00, 0, 0);
        chk("miss_one_cycle", miss, 1'b0);

        // Reset in the middle of play
        ticks(65, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00, 0, 1);
        chk("midplay_rst_state", state, 2'b00);
        chk("midplay_rst_score", score_l, 4'd0);
        probe_at(40, 186, "midplay_rst_pad");
        chk("midplay_rst_pad_c", graph_rgb, 3'b101);

        // Right paddle held down: clamps at 372 and returns the ball
        step(0, 2'b00, 2'b10, 1, 0);
        ticks(60 + 92, 2'b00, 2'b10);
        step(1, 2'b00, 2'b10, 0, 0);
        chk("hit_r_pulse", hit_r, 1'b1);
        step(0, 2'b00, 2'b10, 0, 0);
        chk("hit_r_one_cycle", hit_r, 1'b0);
        probe_at(600, 372, "padr_top");
        chk("padr_top_c", graph_rgb, 3'b101);
        probe_at(600, 371, "padr_above");
        ticks(10, 2'b00, 2'b11);
        probe_at(605, 479, "padr_static");
        chk("padr_static_c", graph_rgb, 3'b101);
        probe_at(605, 371, "padr_static_above");

        // Left player wins with identical rallies
        step(0, 2'b00, 2'b00, 0, 1);
        step(0, 2'b00, 2'b00, 1, 0);
        for (int i = 0; i < 2000 && m_mode != M_OVER; i++)
            ticks(1, 2'b00, 2'b00);
        chk("win_state", state, 2'b11);
        chk("win_winner", winner, 2'b01);
        chk("win_score_l", score_l, 4'd9);
        chk("win_score_r", score_r, 4'd0);
        ticks(5, 2'b01, 2'b10);
        probe_at(316, 236, "over_hidden");
        chk("over_hidden_c", graph_rgb, 3'b000);
        chk("over_hold", winner, 2'b01);
        step(0, 2'b00, 2'b00, 1, 0);
        chk("over_to_idle", state, 2'b00);
        step(0, 2'b00, 2'b00, 1, 0);
        chk("idle_to_serve", state, 2'b01);
        chk("restart_score", score_l, 4'd0);
        chk("restart_winner", winner, 2'b00);

        // Randomized play
        for (int i = 0; i < 5000; i++) begin
            tk = ($urandom_range(0, 1) == 1);
            bl = 2'($urandom_range(0, 3));
            br = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 1499) == 0);
            step(tk, bl, br, st, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
